mem_port_arb: RTL

- Single-port instruction/data memory arbiter between the fetch stage (instruction reads) and the load/store unit (data reads/writes).
- Grants one access per cycle and tracks in-flight reads through a tag pipe matching the memory read latency, so each response returns to its owner.
- Uses data-first priority with a starvation guard, so fetch is guaranteed forward progress.
- Drives `fetch_stall` into the pipe interlock logic.

---
 rtl/mem_port_arb_if.sv | 43 ++++
 rtl/mem_port_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb_if.sv
// Bus bundle between the fetch stage, the load/store unit, the single-port
// memory and the arbiter that shares the memory between them.
interface mem_port_arb_if;
  // fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        fetch_stall;
  // load/store side
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  // memory side
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_dat_in;
  logic [31:0] mem_dat_out;

  // arbiter view
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_dat_out,
    output if_gnt, if_rvalid, if_rdata, fetch_stall,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_dat_in
  );

  // requester / memory view
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_dat_out,
    input  if_gnt, if_rvalid, if_rdata, fetch_stall,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_dat_in
  );
endinterface

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store normally wins; after MAX_LS_STREAK consecutive load/store grants
// with fetch waiting, fetch is forced for one grant. In-flight reads are
// tracked through a MEM_LAT-deep tag pipe so each response returns to its
// owner in grant order.
module mem_port_arb #(
  parameter int MEM_LAT       = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.slave  bus
);

  typedef enum logic [0:0] {
    LS_PRI   = 1'b0,
    IF_FORCE = 1'b1
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;
  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_LS_STREAK);

  arb_state_t          state_r;
  arb_state_t          state_s;
  logic [3:0]          streak_r;
  logic [3:0]          streak_s;
  logic                if_gnt_s;
  logic                ls_gnt_s;
  logic                rd_issue_s;
  logic                rd_own_s;
  logic [MEM_LAT-1:0]  tag_vld_r;
  logic [MEM_LAT-1:0]  tag_own_r;
  logic                ret_vld_s;
  logic                if_rvalid_s;
  logic                ls_rvalid_s;
  logic [31:0]         if_rdata_r;
  logic [31:0]         ls_rdata_r;

  // Grant selection: the FSM state decides who wins when both request.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (rst) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else begin
      case (state_r)
        LS_PRI: begin
          ls_gnt_s = bus.ls_req;
          if_gnt_s = bus.if_req & ~bus.ls_req;
        end
        IF_FORCE: begin
          if_gnt_s = bus.if_req;
          ls_gnt_s = bus.ls_req & ~bus.if_req;
        end
        default: begin
          ls_gnt_s = bus.ls_req;
          if_gnt_s = bus.if_req & ~bus.ls_req;
        end
      endcase
    end
  end

  // Next state and load/store streak count while fetch is waiting.
  always_comb begin
    state_s  = state_r;
    streak_s = streak_r;
    case (state_r)
      LS_PRI: begin
        if (if_gnt_s || !bus.if_req) begin
          streak_s = 4'd0;
        end else if (ls_gnt_s) begin
          streak_s = (streak_r == 4'd15) ? 4'd15 : streak_r + 4'd1;
        end else begin
          streak_s = streak_r;
        end
        if (streak_s >= STREAK_LIMIT) begin
          state_s = IF_FORCE;
        end else begin
          state_s = LS_PRI;
        end
      end
      IF_FORCE: begin
        // one forced fetch grant, or fetch gave up: back to data priority
        if (if_gnt_s || !bus.if_req) begin
          state_s  = LS_PRI;
          streak_s = 4'd0;
        end else begin
          state_s  = IF_FORCE;
          streak_s = streak_r;
        end
      end
      default: begin
        state_s  = LS_PRI;
        streak_s = 4'd0;
      end
    endcase
  end

  // FSM state and streak counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= LS_PRI;
      streak_r <= 4'd0;
    end else begin
      state_r  <= state_s;
      streak_r <= streak_s;
    end
  end

  // Memory strobe and payload mux for the granted requester.
  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'h0;
    bus.mem_addr   = 32'h0;
    bus.mem_dat_in = 32'h0;
    if (if_gnt_s) begin
      bus.mem_en     = 1'b1;
      bus.mem_we     = 1'b0;
      bus.mem_be     = 4'hF;
      bus.mem_addr   = bus.if_addr;
      bus.mem_dat_in = 32'h0;
    end else if (ls_gnt_s) begin
      bus.mem_en     = 1'b1;
      bus.mem_we     = bus.ls_we;
      bus.mem_be     = bus.ls_be;
      bus.mem_addr   = bus.ls_addr;
      bus.mem_dat_in = bus.ls_wdata;
    end else begin
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_be     = 4'h0;
      bus.mem_addr   = 32'h0;
      bus.mem_dat_in = 32'h0;
    end
  end

  // Tag for the read issued this cycle; writes produce no response.
  always_comb begin
    rd_issue_s = if_gnt_s | (ls_gnt_s & ~bus.ls_we);
    rd_own_s   = OWN_IF;
    if (ls_gnt_s) begin
      rd_own_s = OWN_LS;
    end else begin
      rd_own_s = OWN_IF;
    end
  end

  // Tag pipe: one stage per cycle of memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= '0;
      tag_own_r <= '0;
    end else begin
      tag_vld_r[0] <= rd_issue_s;
      tag_own_r[0] <= rd_issue_s ? rd_own_s : OWN_IF;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_own_r[i] <= tag_own_r[i-1];
      end
    end
  end

  // Response routing; reset suppresses any retiring response.
  always_comb begin
    ret_vld_s   = tag_vld_r[MEM_LAT-1] & ~rst;
    if_rvalid_s = ret_vld_s & (tag_own_r[MEM_LAT-1] == OWN_IF);
    ls_rvalid_s = ret_vld_s & (tag_own_r[MEM_LAT-1] == OWN_LS);
  end

  // Read data holding registers keep the last returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_r <= 32'h0;
      ls_rdata_r <= 32'h0;
    end else begin
      if (if_rvalid_s) begin
        if_rdata_r <= bus.mem_dat_out;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (ls_rvalid_s) begin
        ls_rdata_r <= bus.mem_dat_out;
      end else begin
        ls_rdata_r <= ls_rdata_r;
      end
    end
  end

  // Requester-facing outputs; the returning word bypasses the hold register.
  always_comb begin
    bus.if_gnt      = if_gnt_s;
    bus.ls_gnt      = ls_gnt_s;
    bus.fetch_stall = ~rst & bus.if_req & ~if_gnt_s;
    bus.if_rvalid   = if_rvalid_s;
    bus.ls_rvalid   = ls_rvalid_s;
    if (rst) begin
      bus.if_rdata = 32'h0;
      bus.ls_rdata = 32'h0;
    end else begin
      bus.if_rdata = if_rvalid_s ? bus.mem_dat_out : if_rdata_r;
      bus.ls_rdata = ls_rvalid_s ? bus.mem_dat_out : ls_rdata_r;
    end
  end

endmodule
